// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM/servo pulse train (high width, period, 3-bit duty code, loss of signal).
// Optional build macro GLITCH_FILTER_EN adds a FILTER_CYCLES stability filter after the synchroniser.
`default_nettype none

module pwm_capture #(
  parameter int CLK_DIV       = 20,
  parameter int CNT_WIDTH     = 9,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwmIn,
  output logic [CNT_WIDTH-1:0] pulseWidth,
  output logic [CNT_WIDTH-1:0] period,
  output logic [2:0]           dutyCode,
  output logic                 sampleValid,
  output logic                 signalLost
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  if (CLK_DIV < 2 || FILTER_CYCLES < 1) begin : g_param_check
    $error("pwm_capture: CLK_DIV must be >= 2 and FILTER_CYCLES >= 1");
  end

  logic           r_sync1, r_sync2, r_prev;
  logic           w_level, w_rise, w_fall, w_tick, w_toExpire;
  logic           w_emit, w_lose;
  logic [PW-1:0]  r_presc;
  logic [TW-1:0]  r_timeout, w_toNext;
  logic [CNT_WIDTH-1:0] r_highCnt, r_periodCnt, r_width;
  logic [CNT_WIDTH-1:0] w_highNext, w_periodNext;
  logic [CNT_WIDTH-1:0] r_pulseWidth, r_period;
  logic [2:0]     r_dutyCode;
  logic           r_sampleValid, r_signalLost;
  state_t         r_state, w_stateNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwmIn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  logic          r_filt;
  logic [FW-1:0] r_fcnt;

  // Level follows the synced input only after FILTER_CYCLES consecutive clk of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILTER_CYCLES - 1)) begin
      r_filt <= r_sync2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= w_level;
  end

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;
  assign w_tick = (r_presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || w_rise || w_tick) r_presc <= '0;
    else                           r_presc <= r_presc + 1'b1;
  end

  // The tick landing on the closing edge still belongs to the phase being closed.
  assign w_highNext   = (w_tick && r_highCnt != c_CNT_MAX) ? r_highCnt + 1'b1 : r_highCnt;
  assign w_periodNext = (w_tick && r_periodCnt != c_CNT_MAX) ? r_periodCnt + 1'b1 : r_periodCnt;
  assign w_toNext     = w_tick ? r_timeout + 1'b1 : r_timeout;
  assign w_toExpire   = w_tick && (r_timeout == TW'(TIMEOUT_TICKS - 1));

  function automatic logic [2:0] f_duty(input logic [CNT_WIDTH-1:0] w);
    logic [31:0] v;
    v = 32'(w);
    if      (v >= 32'd128) f_duty = 3'd7;
    else if (v >= 32'd64)  f_duty = 3'd6;
    else if (v >= 32'd32)  f_duty = 3'd5;
    else if (v >= 32'd16)  f_duty = 3'd4;
    else if (v >= 32'd8)   f_duty = 3'd3;
    else if (v >= 32'd4)   f_duty = 3'd2;
    else if (v >= 32'd2)   f_duty = 3'd1;
    else                   f_duty = 3'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_emit      = 1'b0;
    w_lose      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_stateNext = S_HIGH;
      end
      S_HIGH: begin
        if (w_fall) begin
          w_stateNext = S_LOW;
        end else if (w_toExpire) begin
          w_stateNext = S_IDLE;
          w_lose      = 1'b1;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_stateNext = S_HIGH;
          w_emit      = 1'b1;
        end else if (w_toExpire) begin
          w_stateNext = S_IDLE;
          w_lose      = 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_highCnt     <= '0;
      r_periodCnt   <= '0;
      r_width       <= '0;
      r_timeout     <= '0;
      r_pulseWidth  <= '0;
      r_period      <= '0;
      r_dutyCode    <= 3'd0;
      r_sampleValid <= 1'b0;
      r_signalLost  <= 1'b1;
    end else begin
      r_sampleValid <= w_emit;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_highCnt   <= '0;
            r_periodCnt <= '0;
            r_timeout   <= '0;
          end
        end
        S_HIGH: begin
          r_highCnt   <= w_highNext;
          r_periodCnt <= w_periodNext;
          if (w_fall) begin
            r_width   <= w_highNext;
            r_timeout <= '0;
          end else begin
            r_timeout <= w_toNext;
          end
        end
        S_LOW: begin
          if (w_rise) begin
            r_pulseWidth <= r_width;
            r_period     <= w_periodNext;
            r_dutyCode   <= f_duty(r_width);
            r_signalLost <= 1'b0;
            r_highCnt    <= '0;
            r_periodCnt  <= '0;
            r_timeout    <= '0;
          end else begin
            r_periodCnt <= w_periodNext;
            r_timeout   <= w_toNext;
          end
        end
        default: ;
      endcase
      if (w_lose) r_signalLost <= 1'b1;
    end
  end

  assign pulseWidth  = r_pulseWidth;
  assign period      = r_period;
  assign dutyCode    = r_dutyCode;
  assign sampleValid = r_sampleValid;
  assign signalLost  = r_signalLost;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table-driven periods plus directed timeout, saturation, reset and glitch sequences.
`default_nettype none

module tb_pwm_capture;

  localparam int DIV = 4;
  localparam int CW  = 9;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0, reset = 1'b1, pwm_a = 1'b0, pwm_b = 1'b0;
  logic [CW-1:0] pw_a, per_a, pw_b, per_b;
  logic [2:0]    duty_a, duty_b;
  logic          sv_a, lost_a, sv_b, lost_b;

  pwm_capture #(.CLK_DIV(DIV), .CNT_WIDTH(CW), .TIMEOUT_TICKS(100), .FILTER_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .pwmIn(pwm_a), .pulseWidth(pw_a), .period(per_a),
    .dutyCode(duty_a), .sampleValid(sv_a), .signalLost(lost_a));

  pwm_capture #(.CLK_DIV(DIV), .CNT_WIDTH(CW), .TIMEOUT_TICKS(1000), .FILTER_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .pwmIn(pwm_b), .pulseWidth(pw_b), .period(per_b),
    .dutyCode(duty_b), .sampleValid(sv_b), .signalLost(lost_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int w; int p; int d; int c;} samp_t;
  typedef struct {int h; int l; int w; int p; int d;} vec_t;

  samp_t qa[$];
  samp_t qb[$];
  int tests = 0, fails = 0, rise_a = 0;

  always @(negedge clk) begin
    if (sv_a === 1'b1) qa.push_back('{int'(pw_a), int'(per_a), int'(duty_a), cyc});
    if (sv_b === 1'b1) qb.push_back('{int'(pw_b), int'(per_b), int'(duty_b), cyc});
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic hold_a(input logic v, input int n);
    if (v && !pwm_a) rise_a = cyc;
    pwm_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_b(input logic v, input int n);
    pwm_b = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string nm, input int w, input int p, input int d, input bit lat);
    samp_t s;
    chk({nm, "_strobes"}, qa.size(), 1);
    if (qa.size() > 0) begin
      s = qa.pop_front();
      qa.delete();
      chk({nm, "_width"}, s.w, w);
      chk({nm, "_period"}, s.p, p);
      chk({nm, "_duty"}, s.d, d);
      if (lat) chk({nm, "_latency"}, s.c - rise_a, LAT);
      chk({nm, "_lost"}, int'(lost_a), 0);
    end
  endtask

  task automatic expect_b(input string nm, input int w, input int p, input int d);
    samp_t s;
    chk({nm, "_strobes"}, qb.size(), 1);
    if (qb.size() > 0) begin
      s = qb.pop_front();
      qb.delete();
      chk({nm, "_width"}, s.w, w);
      chk({nm, "_period"}, s.p, p);
      chk({nm, "_duty"}, s.d, d);
    end
  endtask

  task automatic expect_none_a(input string nm);
    chk(nm, qa.size(), 0);
    qa.delete();
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{40,  160, 10, 50,  3};
    tbl[1]  = '{40,  160, 10, 50,  3};
    tbl[2]  = '{40,  160, 10, 50,  3};
    tbl[3]  = '{4,   196, 1,  50,  0};
    tbl[4]  = '{8,   192, 2,  50,  1};
    tbl[5]  = '{12,  188, 3,  50,  1};
    tbl[6]  = '{64,  136, 16, 50,  4};
    tbl[7]  = '{20,  300, 5,  80,  2};
    tbl[8]  = '{130, 50,  32, 45,  5};
    tbl[9]  = '{392, 8,   98, 100, 6};
    tbl[10] = '{100, 100, 25, 50,  4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_width",  int'(pw_a),   0);
    chk("rst_period", int'(per_a),  0);
    chk("rst_duty",   int'(duty_a), 0);
    chk("rst_valid",  int'(sv_a),   0);
    chk("rst_lost",   int'(lost_a), 1);
    reset = 1'b0;
    hold_a(1'b0, 5);

    for (int i = 0; i < 11; i++) begin
      hold_a(1'b1, tbl[i].h);
      hold_a(1'b0, tbl[i].l);
      if (i == 0) begin
        expect_none_a("first_rise_no_strobe");
        chk("lost_before_lock", int'(lost_a), 1);
      end else begin
        expect_a($sformatf("vec%0d", i - 1), tbl[i-1].w, tbl[i-1].p, tbl[i-1].d, 1'b1);
      end
    end
    hold_a(1'b1, 20);
    expect_a("vec10", tbl[10].w, tbl[10].p, tbl[10].d, 1'b1);

    // Stuck high: loss declared exactly 100 ticks after the last rise is seen.
    hold_a(1'b1, 377 + LAT);
    chk("stuck_high_not_yet", int'(lost_a), 0);
    hold_a(1'b1, 3);
    chk("stuck_high_lost", int'(lost_a), 1);
    chk("held_width",  int'(pw_a),   25);
    chk("held_period", int'(per_a),  50);
    chk("held_duty",   int'(duty_a), 4);

    hold_a(1'b0, 20);
    hold_a(1'b1, 40);
    hold_a(1'b0, 160);
    expect_none_a("rearm_no_strobe");
    chk("rearm_still_lost", int'(lost_a), 1);
    hold_a(1'b1, 40);
    expect_a("relock", 10, 50, 3, 1'b1);
    hold_a(1'b0, 410);
    chk("stuck_low_lost", int'(lost_a), 1);
    chk("stuck_low_held_width", int'(pw_a), 10);

    hold_b(1'b1, 600);
    hold_b(1'b0, 1400);
    hold_b(1'b1, 600);
    expect_b("long", 150, 500, 7);
    hold_b(1'b1, 1800);
    hold_b(1'b0, 1200);
    hold_b(1'b1, 20);
    expect_b("saturate", 511, 511, 7);

    hold_a(1'b1, 40);
    hold_a(1'b0, 160);
    hold_a(1'b1, 20);
    expect_a("pre_reset", 10, 50, 3, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_width",  int'(pw_a),   0);
    chk("midrst_period", int'(per_a),  0);
    chk("midrst_duty",   int'(duty_a), 0);
    chk("midrst_valid",  int'(sv_a),   0);
    chk("midrst_lost",   int'(lost_a), 1);
    pwm_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_none_a("reset_no_strobe");
    hold_a(1'b0, 20);
    hold_a(1'b1, 40);
    hold_a(1'b0, 160);
    expect_none_a("post_reset_arm");

    hold_a(1'b1, 16);
    expect_a("pre_glitch", 10, 50, 3, 1'b1);
    hold_a(1'b0, 2);
    hold_a(1'b1, 22);
    hold_a(1'b0, 160);
`ifdef GLITCH_FILTER_EN
    expect_none_a("glitch_ignored");
    hold_a(1'b1, 20);
    expect_a("glitch_width", 10, 50, 3, 1'b1);
`else
    expect_a("glitch_cut", 4, 4, 2, 1'b1);
    hold_a(1'b1, 20);
    expect_a("glitch_tail", 5, 45, 2, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
